// File: rtl/friscv_rv32i_pkg.sv
// Shared RV32I definitions for the encoder and decoder: major opcodes,
// instruction formats and the bit positions of the fixed fields.
package friscv_rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  localparam int IMM_I_LSB  = 20;
  localparam int IMM_U_LSB  = 12;

  // Unknown opcodes fall back to the R layout.
  function automatic fmt_e opcode_format(input logic [6:0] opcode);
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: opcode_format = FMT_I;
      OPC_STORE:          opcode_format = FMT_S;
      OPC_BRANCH:         opcode_format = FMT_B;
      OPC_LUI, OPC_AUIPC: opcode_format = FMT_U;
      OPC_JAL:            opcode_format = FMT_J;
      default:            opcode_format = FMT_R;
    endcase
  endfunction

  function automatic logic opcode_known(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: opcode_known = 1'b1;
      default: opcode_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO with a registered occupancy count; the head word is
// visible on pop_data whenever the FIFO is not empty.
module friscv_scfifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & !full;
  assign do_pop   = pop & !empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/friscv_rv32i_encoder.sv
// Builds RV32I words from field requests and streams them out through a FIFO.
// Define FRISCV_ENC_CHECK_EN to reject malformed requests instead of truncating them.
module friscv_rv32i_encoder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            aclk,
  input  logic            srst,
  input  logic            enc_valid,
  output logic            enc_ready,
  input  logic [6:0]      enc_opcode,
  input  logic [2:0]      enc_funct3,
  input  logic [6:0]      enc_funct7,
  input  logic [4:0]      enc_rd,
  input  logic [4:0]      enc_rs1,
  input  logic [4:0]      enc_rs2,
  input  logic [31:0]     enc_imm,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic            enc_error,
  output logic [7:0]      err_count
);

  import friscv_rv32i_pkg::*;

  fmt_e            fmt;
  logic [11:0]     imm12;
  logic [XLEN-1:0] word;
  logic            req_ok;
  logic            accept;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [XLEN-1:0] fifo_head;
  logic [XLEN-1:0] last_q;

  // Only the fields belonging to the selected layout reach the word.
  always_comb begin
    fmt   = opcode_format(enc_opcode);
    imm12 = (enc_opcode == OPC_MISC_MEM) ? {4'b0000, enc_imm[7:0]} : enc_imm[11:0];
    word  = '0;
    word[OPCODE_LSB +: 7] = enc_opcode;
    case (fmt)
      FMT_I: begin
        word[RD_LSB +: 5]     = enc_rd;
        word[FUNCT3_LSB +: 3] = enc_funct3;
        word[RS1_LSB +: 5]    = enc_rs1;
        word[IMM_I_LSB +: 12] = imm12;
      end
      FMT_S: begin
        word[RD_LSB +: 5]     = enc_imm[4:0];
        word[FUNCT3_LSB +: 3] = enc_funct3;
        word[RS1_LSB +: 5]    = enc_rs1;
        word[RS2_LSB +: 5]    = enc_rs2;
        word[FUNCT7_LSB +: 7] = enc_imm[11:5];
      end
      FMT_B: begin
        word[RD_LSB +: 5]     = {enc_imm[4:1], enc_imm[11]};
        word[FUNCT3_LSB +: 3] = enc_funct3;
        word[RS1_LSB +: 5]    = enc_rs1;
        word[RS2_LSB +: 5]    = enc_rs2;
        word[FUNCT7_LSB +: 7] = {enc_imm[12], enc_imm[10:5]};
      end
      FMT_U: begin
        word[RD_LSB +: 5]     = enc_rd;
        word[IMM_U_LSB +: 20] = enc_imm[31:12];
      end
      FMT_J: begin
        word[RD_LSB +: 5]     = enc_rd;
        word[IMM_U_LSB +: 20] = {enc_imm[20], enc_imm[10:1], enc_imm[11], enc_imm[19:12]};
      end
      default: begin
        word[RD_LSB +: 5]     = enc_rd;
        word[FUNCT3_LSB +: 3] = enc_funct3;
        word[RS1_LSB +: 5]    = enc_rs1;
        word[RS2_LSB +: 5]    = enc_rs2;
        word[FUNCT7_LSB +: 7] = enc_funct7;
      end
    endcase
  end

`ifdef FRISCV_ENC_CHECK_EN
  // Immediate must be representable in its field once sign-extended back.
  always_comb begin
    req_ok = opcode_known(enc_opcode);
    case (fmt)
      FMT_I, FMT_S: if (enc_imm[31:11] != {21{enc_imm[11]}}) req_ok = 1'b0;
      FMT_B: if ((enc_imm[31:12] != {20{enc_imm[12]}}) || enc_imm[0]) req_ok = 1'b0;
      FMT_J: if ((enc_imm[31:20] != {12{enc_imm[20]}}) || enc_imm[0]) req_ok = 1'b0;
      FMT_U: if (enc_imm[11:0] != 12'd0) req_ok = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      enc_error <= 1'b0;
      err_count <= 8'd0;
    end else begin
      enc_error <= accept & !req_ok;
      if (accept && !req_ok && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end
`else
  assign req_ok    = 1'b1;
  assign enc_error = 1'b0;
  assign err_count = 8'd0;
`endif

  assign enc_ready = !srst && !fifo_full;
  assign accept    = enc_valid & enc_ready;
  assign fifo_push = accept & req_ok;
  assign fifo_pop  = inst_ready & !fifo_empty;

  friscv_scfifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk       (aclk),
    .srst      (srst),
    .push      (fifo_push),
    .push_data (word),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Remember the last delivered word so an empty FIFO keeps inst_data steady.
  always_ff @(posedge aclk) begin
    if (srst)          last_q <= '0;
    else if (fifo_pop) last_q <= fifo_head;
  end

  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_empty ? last_q : fifo_head;

endmodule

// File: tb/tb_friscv_rv32i_encoder.sv
// Bench for friscv_rv32i_encoder: directed encodings and FIFO corner cases, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_friscv_rv32i_encoder;

  localparam int DEPTH = 4;
`ifdef FRISCV_ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        srst;
  logic        enc_valid;
  logic        enc_ready;
  logic [6:0]  enc_opcode;
  logic [2:0]  enc_funct3;
  logic [6:0]  enc_funct7;
  logic [4:0]  enc_rd;
  logic [4:0]  enc_rs1;
  logic [4:0]  enc_rs2;
  logic [31:0] enc_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        enc_error;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelQ [$];
  logic [31:0] modelHold = '0;
  bit          modelErr = 1'b0;
  int          modelErrCount = 0;
  bit          modelLive = 1'b0;

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                           7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  always #5 aclk = ~aclk;

  friscv_rv32i_encoder #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .aclk       (aclk),
    .srst       (srst),
    .enc_valid  (enc_valid),
    .enc_ready  (enc_ready),
    .enc_opcode (enc_opcode),
    .enc_funct3 (enc_funct3),
    .enc_funct7 (enc_funct7),
    .enc_rd     (enc_rd),
    .enc_rs1    (enc_rs1),
    .enc_rs2    (enc_rs2),
    .enc_imm    (enc_imm),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .enc_error  (enc_error),
    .err_count  (err_count)
  );

  function automatic bit fitsSigned(input logic [31:0] v, input int bits);
    longint s;
    longint lim;
    s   = longint'($signed(v));
    lim = longint'(1) << (bits - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  // Reference encoder: layouts straight from the ISA field tables.
  function automatic logic [31:0] modelEncode(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, output bit ok);
    logic [31:0] w;
    logic [11:0] i12;
    i12 = (op == 7'h0F) ? {4'b0000, imm[7:0]} : imm[11:0];
    case (op)
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
        w  = {i12, rs1, f3, rd, op};
        ok = fitsSigned(imm, 12);
      end
      7'h23: begin
        w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        ok = fitsSigned(imm, 12);
      end
      7'h63: begin
        w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        ok = fitsSigned(imm, 13) && (imm[0] == 1'b0);
      end
      7'h37, 7'h17: begin
        w  = {imm[31:12], rd, op};
        ok = (imm[11:0] == 12'd0);
      end
      7'h6F: begin
        w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        ok = fitsSigned(imm, 21) && (imm[0] == 1'b0);
      end
      7'h33: begin
        w  = {f7, rs2, rs1, f3, rd, op};
        ok = 1'b1;
      end
      default: begin
        w  = {f7, rs2, rs1, f3, rd, op};
        ok = 1'b0;
      end
    endcase
    if (!CHECK_EN) ok = 1'b1;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    enc_valid  = v;
    enc_opcode = op;
    enc_funct3 = f3;
    enc_funct7 = f7;
    enc_rd     = rd;
    enc_rs1    = rs1;
    enc_rs2    = rs2;
    enc_imm    = imm;
  endtask

  task automatic pushAddi(input int imm);
    applyStimulus(1'b1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(imm));
  endtask

  // Pin the model to a literal, then send the request into an empty FIFO and
  // expect the word on the output one cycle after acceptance.
  task automatic sendExpect(input string name, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] lit);
    bit ok;
    logic [31:0] w;
    w = modelEncode(op, f3, f7, rd, rs1, rs2, imm, ok);
    checkOutput({name, " model"}, w, lit);
    tick();
    inst_ready = 1'b0;
    applyStimulus(1'b1, op, f3, f7, rd, rs1, rs2, imm);
    tick();
    enc_valid = 1'b0;
    @(negedge aclk);
    checkOutput({name, " inst_valid"}, inst_valid, 1);
    checkOutput({name, " inst_data"}, inst_data, lit);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  // Model advances on the edge using the inputs the DUT also sees.
  always @(posedge aclk) begin
    logic [31:0] w;
    bit ok;
    bit acc;
    bit pop;
    if (srst) begin
      modelQ.delete();
      modelHold     = '0;
      modelErr      = 1'b0;
      modelErrCount = 0;
      modelLive     = 1'b1;
    end else if (modelLive) begin
      acc = enc_valid && (modelQ.size() < DEPTH);
      pop = inst_ready && (modelQ.size() > 0);
      w   = modelEncode(enc_opcode, enc_funct3, enc_funct7, enc_rd, enc_rs1, enc_rs2, enc_imm, ok);
      if (pop) modelHold = modelQ.pop_front();
      if (acc && ok) modelQ.push_back(w);
      modelErr = acc && !ok;
      if (modelErr && modelErrCount < 255) modelErrCount++;
    end
  end

  always @(negedge aclk) begin
    if (modelLive) begin
      checkOutput("enc_ready", enc_ready, (!srst && (modelQ.size() < DEPTH)));
      checkOutput("inst_valid", inst_valid, (modelQ.size() > 0));
      checkOutput("inst_data", inst_data, (modelQ.size() > 0) ? modelQ[0] : modelHold);
      checkOutput("enc_error", enc_error, modelErr);
      checkOutput("err_count", err_count, 32'(modelErrCount));
    end
  end

  initial begin
    int seen;
    srst       = 1'b1;
    inst_ready = 1'b0;
    applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) tick();
    @(negedge aclk);
    checkOutput("reset enc_ready", enc_ready, 0);
    checkOutput("reset inst_valid", inst_valid, 0);
    checkOutput("reset inst_data", inst_data, 0);
    checkOutput("reset err_count", err_count, 0);
    tick();
    srst = 1'b0;
    @(negedge aclk);
    checkOutput("post-reset enc_ready", enc_ready, 1);

    $display("[TB] directed encodings");
    sendExpect("addi", 7'h13, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd31, 32'd5, 32'h00500093);
    sendExpect("beq", 7'h63, 3'd0, 7'h7F, 5'd31, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE208CE3);
    sendExpect("jal", 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF);
    sendExpect("lui", 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7);

    $display("[TB] fill to full and drain");
    for (int i = 0; i < 4; i++) begin
      pushAddi(i + 1);
      tick();
    end
    enc_valid = 1'b0;
    @(negedge aclk);
    checkOutput("full enc_ready", enc_ready, 0);
    checkOutput("full head", inst_data, 32'h00100093);
    inst_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      @(negedge aclk);
      if (i == 2) checkOutput("enc_ready after pop", enc_ready, 1);
      checkOutput("drain order", inst_data, 32'h00000093 | (32'(i) << 20));
    end
    tick();
    @(negedge aclk);
    checkOutput("empty inst_valid", inst_valid, 0);
    checkOutput("empty holds last", inst_data, 32'h00400093);
    inst_ready = 1'b0;

    $display("[TB] simultaneous push and pop");
    tick();
    pushAddi(10);
    tick();
    pushAddi(11);
    tick();
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pushAddi(20 + k);
      tick();
      @(negedge aclk);
      checkOutput("stream enc_ready", enc_ready, 1);
      checkOutput("stream head", inst_data,
                  32'h00000093 | (32'((k == 0) ? 11 : 19 + k) << 20));
    end
    enc_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (inst_valid) seen++;
      tick();
      @(negedge aclk);
    end
    checkOutput("stream residue", 32'(seen), 2);
    inst_ready = 1'b0;

`ifdef FRISCV_ENC_CHECK_EN
    $display("[TB] request checking");
    tick();
    applyStimulus(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    tick();
    enc_valid = 1'b0;
    @(negedge aclk);
    checkOutput("bad beq enc_error", enc_error, 1);
    checkOutput("bad beq err_count", err_count, 1);
    checkOutput("bad beq not queued", inst_valid, 0);
    tick();
    @(negedge aclk);
    checkOutput("enc_error pulse", enc_error, 0);
    tick();
    applyStimulus(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    repeat (256) tick();
    enc_valid = 1'b0;
    tick();
    @(negedge aclk);
    checkOutput("err_count saturates", err_count, 255);
`else
    $display("[TB] truncation and unknown opcode");
    sendExpect("beq odd imm", 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00208163);
    sendExpect("unknown op", 7'h7F, 3'd4, 7'd1, 5'd5, 5'd3, 5'd2, 32'hFFFF_FFFF, 32'h0221C2FF);
    checkOutput("no enc_error", enc_error, 0);
    checkOutput("no err_count", err_count, 0);
`endif

    $display("[TB] reset with queued words");
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pushAddi(30 + i);
      tick();
    end
    enc_valid = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    @(negedge aclk);
    checkOutput("flush inst_valid", inst_valid, 0);
    checkOutput("flush inst_data", inst_data, 0);
    checkOutput("flush enc_ready", enc_ready, 1);
    sendExpect("addi after flush", 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 32'h00700093);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] imm;
      logic [6:0]  op;
      imm = $urandom;
      case ($urandom_range(0, 4))
        0: imm = {{20{imm[11]}}, imm[11:0]};
        1: imm = {{19{imm[12]}}, imm[12:1], 1'b0};
        2: imm = {imm[31:12], 12'd0};
        3: imm = {{11{imm[20]}}, imm[20:1], 1'b0};
        default: ;
      endcase
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      applyStimulus($urandom_range(0, 3) != 0, op, 3'($urandom), 7'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom), imm);
      inst_ready = ($urandom_range(0, 2) != 0);
      srst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    srst       = 1'b0;
    enc_valid  = 1'b0;
    inst_ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
